dmem_miss_responder: RTL and testbench

Backing data-memory responder for the L1 data cache in the OoO RISC-V core. Accepts miss and store-through requests emitted by the cache (cache_miss, optype_out, address_out, reg_out, inst_pc_out, datasw_out), queues them in a small FIFO, and services them one at a time against a word-addressed memory with fixed latency. Returns each result with its destination tag and PC to the cache refill and writeback path.

---
 rtl/dmem_miss_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_miss_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_miss_responder.sv
// rtl/dmem_miss_responder.sv - queued fixed-latency backing memory for L1 data-cache misses and store-throughs
module dmem_miss_responder #(
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic [3:0]  req_optype,
    input  logic [31:0] req_addr,
    input  logic [5:0]  req_reg,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_data,
    output logic        req_ready,
    output logic        resp_valid,
    output logic        resp_store,
    output logic [3:0]  resp_optype,
    output logic [31:0] resp_pc,
    output logic [31:0] resp_addr,
    output logic [5:0]  resp_reg,
    output logic [31:0] resp_data,
    output logic        busy
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [3:0] OP_LB = 4'd7;
    localparam logic [3:0] OP_LW = 4'd8;
    localparam logic [3:0] OP_SB = 4'd9;
    localparam logic [3:0] OP_SW = 4'd10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [3:0]  r_fifo_op   [DEPTH];
    logic [31:0] r_fifo_addr [DEPTH];
    logic [5:0]  r_fifo_reg  [DEPTH];
    logic [31:0] r_fifo_pc   [DEPTH];
    logic [31:0] r_fifo_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic [31:0] r_mem [MEM_WORDS];
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]  r_svc_op;
    logic [31:0] r_svc_addr;
    logic [5:0]  r_svc_reg;
    logic [31:0] r_svc_pc;
    logic [31:0] r_svc_data;

    logic        r_resp_valid;
    logic        r_resp_store;
    logic [3:0]  r_resp_op;
    logic [31:0] r_resp_pc;
    logic [31:0] r_resp_addr;
    logic [5:0]  r_resp_reg;
    logic [31:0] r_resp_data;

    logic          w_legal;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;

    assign req_ready = (r_count < (PW+1)'(DEPTH));
    assign w_legal   = (req_optype == OP_LB) || (req_optype == OP_LW) ||
                       (req_optype == OP_SB) || (req_optype == OP_SW);
    assign w_push    = req_valid && req_ready && w_legal;
    // Only IDLE and DONE may refill the service slot.
    assign w_pop     = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && (r_count != '0);

    assign w_idx  = r_svc_addr[AW+1:2];
    assign w_lane = r_svc_addr[1:0];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr]   <= req_optype;
            r_fifo_addr[r_wr_ptr] <= req_addr;
            r_fifo_reg[r_wr_ptr]  <= req_reg;
            r_fifo_pc[r_wr_ptr]   <= req_pc;
            r_fifo_data[r_wr_ptr] <= req_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_svc_op     <= '0;
            r_svc_addr   <= '0;
            r_svc_reg    <= '0;
            r_svc_pc     <= '0;
            r_svc_data   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_store <= 1'b0;
            r_resp_op    <= '0;
            r_resp_pc    <= '0;
            r_resp_addr  <= '0;
            r_resp_reg   <= '0;
            r_resp_data  <= '0;
            for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
        end else begin
            if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PW'(1);
                r_svc_op   <= r_fifo_op[r_rd_ptr];
                r_svc_addr <= r_fifo_addr[r_rd_ptr];
                r_svc_reg  <= r_fifo_reg[r_rd_ptr];
                r_svc_pc   <= r_fifo_pc[r_rd_ptr];
                r_svc_data <= r_fifo_data[r_rd_ptr];
                r_cnt      <= CW'(LATENCY - 1);
            end
            case (r_state)
                ST_IDLE: if (w_pop) r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        if (r_svc_op == OP_SW) r_mem[w_idx] <= r_svc_data;
                        if (r_svc_op == OP_SB) r_mem[w_idx][{w_lane, 3'b000} +: 8] <= r_svc_data[7:0];
                        r_resp_valid <= 1'b1;
                        r_resp_store <= (r_svc_op == OP_SB) || (r_svc_op == OP_SW);
                        r_resp_op    <= r_svc_op;
                        r_resp_pc    <= r_svc_pc;
                        r_resp_addr  <= r_svc_addr;
                        r_resp_reg   <= r_svc_reg;
                        if (r_svc_op == OP_LW)      r_resp_data <= w_word;
                        else if (r_svc_op == OP_LB) r_resp_data <= {24'b0, w_byte};
                        else                        r_resp_data <= r_svc_data;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= w_pop ? ST_WAIT : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_store  = r_resp_store;
    assign resp_optype = r_resp_op;
    assign resp_pc     = r_resp_pc;
    assign resp_addr   = r_resp_addr;
    assign resp_reg    = r_resp_reg;
    assign resp_data   = r_resp_data;
    assign busy        = (r_state != ST_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_dmem_miss_responder.sv
// tb/tb_dmem_miss_responder.sv - table vectors, corner sequences and random traffic against a memory model
module tb_dmem_miss_responder;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_optype = '0;
    logic [31:0] req_addr = '0;
    logic [5:0]  req_reg = '0;
    logic [31:0] req_pc = '0;
    logic [31:0] req_data = '0;
    logic        req_ready, resp_valid, resp_store, busy;
    logic [3:0]  resp_optype;
    logic [31:0] resp_pc, resp_addr, resp_data;
    logic [5:0]  resp_reg;

    dmem_miss_responder #(.DEPTH(4), .LATENCY(L), .MEM_WORDS(1024)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_optype(req_optype),
        .req_addr(req_addr), .req_reg(req_reg), .req_pc(req_pc), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_store(resp_store),
        .resp_optype(resp_optype), .resp_pc(resp_pc), .resp_addr(resp_addr),
        .resp_reg(resp_reg), .resp_data(resp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [5:0]  rg;
        logic [31:0] pc;
        logic [31:0] data;
        logic        exp_store;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [5:0]  rg;
        logic [31:0] pc;
        logic        store;
        logic [31:0] data;
    } resp_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int prev_resp_cyc = -1;
    int last_acc_cyc = 0;
    resp_t exp_q[$];
    int resp_cyc_q[$];
    logic [31:0] mdl_mem [1024];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Reference: memory effects applied in acceptance order, since service is strictly FIFO.
    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [5:0] rg,
                         input logic [31:0] pc, input logic [31:0] data, output resp_t r);
        int idx;
        int sh;
        idx = int'(addr[11:2]);
        sh  = 8 * int'(addr[1:0]);
        r.op = op; r.addr = addr; r.rg = rg; r.pc = pc;
        r.store = (op == 4'd9) || (op == 4'd10);
        r.data = data;
        if (op == 4'd8) r.data = mdl_mem[idx];
        if (op == 4'd7) r.data = (mdl_mem[idx] >> sh) & 32'hFF;
        if (op == 4'd10) mdl_mem[idx] = data;
        if (op == 4'd9) mdl_mem[idx] = (mdl_mem[idx] & ~(32'hFF << sh)) | ((data & 32'hFF) << sh);
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [5:0] rg,
                        input logic [31:0] pc, input logic [31:0] data,
                        input bit use_tab, input logic tab_store, input logic [31:0] tab_data);
        resp_t r;
        int g;
        g = 0;
        req_valid = 1'b1; req_optype = op; req_addr = addr; req_reg = rg; req_pc = pc; req_data = data;
        while (!req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            total++; bad++;
            $display("FAIL send_timeout act=ready_low exp=ready_high");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (op >= 4'd7 && op <= 4'd10) begin
            model(op, addr, rg, pc, data, r);
            if (use_tab) begin
                r.store = tab_store;
                r.data  = tab_data;
            end
            exp_q.push_back(r);
        end
        @(negedge clk);
        req_valid = 1'b0;
        last_acc_cyc = cyc;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || busy) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) begin
            total++; bad++;
            $display("FAIL drain_timeout act=%0d_pending exp=0", exp_q.size());
        end
    endtask

    always @(negedge clk) begin
        resp_t e;
        if (rstn && resp_valid) begin
            resp_cyc_q.push_back(cyc);
            if (prev_resp_cyc >= 0) begin
                total++;
                if (cyc - prev_resp_cyc < L + 1) begin
                    bad++;
                    $display("FAIL resp_gap act=%0d exp>=%0d", cyc - prev_resp_cyc, L + 1);
                end
            end
            prev_resp_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_resp act=addr_%h exp=none", resp_addr);
            end else begin
                e = exp_q.pop_front();
                chk("resp_fields", 128'({resp_optype, resp_addr, resp_reg, resp_pc, resp_store, resp_data}),
                    128'({e.op, e.addr, e.rg, e.pc, e.store, e.data}));
            end
        end
    end

    vec_t tab[11];
    int   bp_acc[6];
    int   bp_exp[6] = '{0, 1, 2, 3, 4, 7};

    initial begin
        int n;
        logic seen;
        logic [3:0] op;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) mdl_mem[i] = '0;
        tab[0]  = '{4'd10, 32'h0000_0100, 6'd1, 32'h0000_1000, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        tab[1]  = '{4'd8,  32'h0000_0100, 6'd5, 32'h0000_1004, 32'h0,        1'b0, 32'hDEADBEEF};
        tab[2]  = '{4'd10, 32'h0000_0200, 6'd2, 32'h0000_1008, 32'h11223344, 1'b1, 32'h11223344};
        tab[3]  = '{4'd9,  32'h0000_0202, 6'd3, 32'h0000_100C, 32'h000000AA, 1'b1, 32'h000000AA};
        tab[4]  = '{4'd8,  32'h0000_0200, 6'd4, 32'h0000_1010, 32'h0,        1'b0, 32'h11AA3344};
        tab[5]  = '{4'd7,  32'h0000_0203, 6'd6, 32'h0000_1014, 32'h0,        1'b0, 32'h00000011};
        tab[6]  = '{4'd7,  32'h0000_0202, 6'd7, 32'h0000_1018, 32'h0,        1'b0, 32'h000000AA};
        tab[7]  = '{4'd10, 32'h0000_1000, 6'd8, 32'h0000_101C, 32'h00000005, 1'b1, 32'h00000005};
        tab[8]  = '{4'd8,  32'h0000_0000, 6'd9, 32'h0000_1020, 32'h0,        1'b0, 32'h00000005};
        tab[9]  = '{4'd9,  32'h0000_0001, 6'd10, 32'h0000_1024, 32'hFFFFFF77, 1'b1, 32'hFFFFFF77};
        tab[10] = '{4'd8,  32'h0000_0000, 6'd11, 32'h0000_1028, 32'h0,       1'b0, 32'h00007705};

        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({req_ready, resp_valid, busy, resp_store, resp_optype, resp_pc, resp_addr, resp_reg, resp_data}),
            128'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 6'd0, 32'd0}));
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            send(tab[i].op, tab[i].addr, tab[i].rg, tab[i].pc, tab[i].data, 1'b1, tab[i].exp_store, tab[i].exp_data);
            wait_resp(n);
            chk("latency", 128'(n), 128'(L + 1));
            @(negedge clk);
            chk("busy_after_done", 128'(busy), 128'(0));
        end

        // Illegal optype: nothing queued, block stays idle.
        send(4'd3, 32'h0000_0040, 6'd1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        seen = 1'b0;
        repeat (10) begin
            if (busy || !req_ready) seen = 1'b1;
            @(negedge clk);
        end
        chk("illegal_idle", 128'(seen), 128'(0));

        // Backpressure: six back-to-back requests, sixth must wait for a slot.
        resp_cyc_q.delete();
        for (int k = 0; k < 6; k++) begin
            op = (k % 2 == 0) ? 4'd10 : 4'd8;
            send(op, 32'h0000_0300 + 32'(4 * (k / 2)), 6'(20 + k), 32'h0000_2000 + 32'(k), $urandom, 1'b0, 1'b0, 32'h0);
            bp_acc[k] = last_acc_cyc;
            if (k == 4) chk("bp_ready_low", 128'(req_ready), 128'(0));
        end
        for (int k = 1; k < 6; k++) chk("bp_accept_cycle", 128'(bp_acc[k] - bp_acc[0]), 128'(bp_exp[k]));
        drain();
        chk("bp_resp_count", 128'(resp_cyc_q.size()), 128'(6));
        if (resp_cyc_q.size() == 6) begin
            chk("bp_first_latency", 128'(resp_cyc_q[0] - bp_acc[0]), 128'(L + 1));
            for (int k = 1; k < 6; k++) chk("bp_spacing", 128'(resp_cyc_q[k] - resp_cyc_q[k-1]), 128'(L + 1));
        end

        // Reset while serving with three queued.
        for (int k = 0; k < 4; k++) send(4'd10, 32'h0000_0100, 6'(k), 32'h3000, 32'hCAFE0000 + 32'(k), 1'b0, 1'b0, 32'h0);
        rstn = 1'b0;
        #1;
        chk("midreset_outputs", 128'({req_ready, resp_valid, busy, resp_store, resp_optype, resp_pc, resp_addr, resp_reg, resp_data}),
            128'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 6'd0, 32'd0}));
        exp_q.delete();
        prev_resp_cyc = -1;
        for (int i = 0; i < 1024; i++) mdl_mem[i] = '0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_reset_queue", 128'(busy), 128'(0));
        send(4'd8, 32'h0000_0100, 6'd5, 32'h4000, 32'h0, 1'b1, 1'b0, 32'h0);
        wait_resp(n);
        chk("post_reset_latency", 128'(n), 128'(L + 1));
        @(negedge clk);

        // Random traffic over a few aliased words (upper address bits vary to exercise wrap).
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 8))
                0, 1:    op = 4'd7;
                2, 3:    op = 4'd8;
                4, 5:    op = 4'd9;
                6, 7:    op = 4'd10;
                default: op = 4'($urandom_range(0, 6));
            endcase
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            send(op, a, 6'($urandom), $urandom, $urandom, 1'b0, 1'b0, 32'h0);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        drain();
        chk("final_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
